corelet_ctrl: RTL and testbench
===============================

// Module: corelet_ctrl
// PURPOSE
//   Top-level sequencer for the corelet datapath (mac_array + l0 + ofifo + sfp). On start it runs one
//   full convolution layer: per kernel index kij it clears the array, loads weights, streams activations,
//   drains ofifo results into psum memory, then drives the sfp accumulation pass and reports done.
//   Drives corelet inst_w/load/acc/mode_2bit and the activation/weight SRAM and psum SRAM ports.
// PARAMETERS
//   row      8   PE rows; weight-load cycles per kij
//   col      8   PE columns; ofifo width in psum words
//   kij_len  9   kernel positions per layer
//   nij_len  16  activation vectors streamed per kij (= ofifo lines expected per kij)
//   acc_len  36  sfp accumulation cycles (acc held high this many cycles)
//   aw       11  SRAM address width
// PORTS
//   clk        in   1   clock, all state on rising edge
//   reset      in   1   synchronous, active-high
//   start      in   1   one-cycle pulse; begins layer when idle
//   cfg_2bit   in   1   activation precision; sampled on accepted start
//   ofifo_vld  in   1   corelet valid (one ofifo line popped this cycle)
//   inst_w     out  2   [1]=execute, [0]=kernel load, to corelet
//   load       out  1   array clear pulse, to corelet
//   acc        out  1   sfp i_valid, to corelet
//   mode_2bit  out  1   latched cfg_2bit, to corelet
//   x_cen      out  1   act/weight SRAM chip enable, active-low
//   x_addr     out  aw  act/weight SRAM read address
//   p_wen      out  1   psum SRAM write enable, active-low
//   p_addr     out  aw  psum SRAM write address
//   busy       out  1   high from accepted start until done
//   done       out  1   one-cycle pulse at layer end
//   err        out  1   sticky: unexpected ofifo_vld
// BEHAVIOUR
//   Reset: state=IDLE; inst_w=0, load=0, acc=0, mode_2bit=0, x_cen=1, x_addr=0, p_wen=1, p_addr=0,
//     busy=0, done=0, err=0; all counters 0. Reset mid-operation aborts to IDLE the next edge, no done.
//   States: IDLE -> CLR -> WLOAD -> WSETTLE -> EXEC -> DRAIN -> (CLR | ACC) -> FIN -> IDLE.
//   IDLE: start=1 -> CLR, kij=0, mode_2bit<=cfg_2bit, busy=1. start while busy is ignored.
//   CLR (1 cyc): load=1 (clears array psums). -> WLOAD.
//   WLOAD (row cyc): x_cen=0, x_addr=kij*row+i, i=0..row-1. SRAM latency is 1 cycle, so inst_w[0]=1
//     is asserted the cycle AFTER each read (row cycles, delayed one). -> WSETTLE.
//   WSETTLE (row+col cyc): inst_w=0, x_cen=1, lets weights propagate. -> EXEC.
//   EXEC (nij_len cyc): x_cen=0, x_addr=kij_len*row+n, n=0..nij_len-1; inst_w[1]=1 one cycle after each read.
//   DRAIN: waits until ofcnt==nij_len; then kij<kij_len-1 -> kij++, CLR; else -> ACC.
//   ofifo_vld counted in EXEC and DRAIN: same cycle p_wen=0, p_addr=kij*nij_len+ofcnt, ofcnt++.
//     ofifo_vld when ofcnt==nij_len or in any other state sets err; no psum write issued.
//   ofcnt clears on entry to CLR. inst_w never has both bits set.
//   ACC (acc_len cyc): acc=1; sfp generates its own addresses. -> FIN.
//   FIN (1 cyc): done=1, busy drops same edge into IDLE. start coincident with done is ignored.
//   Address arithmetic is modulo 2^aw; parameters must keep addresses in range (no check).
// TESTING
//   Reset then start, defaults -> load pulse cycle 1; inst_w=01 for 8 cycles, x_addr 0..7 lead by one.
//   Full layer, bench returns 16 ofifo_vld per kij -> 144 psum writes, p_addr 0..143 in order, done once.
//   cfg_2bit=1 at start, toggled mid-run -> mode_2bit stays 1 until next start.
//   Extra (17th) ofifo_vld in kij 0 -> err=1 sticky, no write, p_addr continues at 16 for kij 1.
//   Reset asserted during EXEC of kij 3 -> next cycle all outputs at reset values, busy=0, no done.
//   start pulsed during EXEC and at done cycle -> no restart; busy stays per single layer.

Source files
------------

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: layer sequencer for the corelet datapath.
// Walks every kernel position through clear/load/exec/drain, then runs the sfp pass.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int kij_len = 9,
  parameter int nij_len = 16,
  parameter int acc_len = 36,
  parameter int aw      = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          cfg_2bit,
  input  logic          ofifo_vld,
  output logic [1:0]    inst_w,
  output logic          load,
  output logic          acc,
  output logic          mode_2bit,
  output logic          x_cen,
  output logic [aw-1:0] x_addr,
  output logic          p_wen,
  output logic [aw-1:0] p_addr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLR     = 3'd1;
  localparam logic [2:0] S_WLOAD   = 3'd2;
  localparam logic [2:0] S_WSETTLE = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_ACC     = 3'd6;
  localparam logic [2:0] S_FIN     = 3'd7;

  localparam int M1 = (row + col > nij_len) ? row + col : nij_len;
  localparam int M2 = (M1 > acc_len) ? M1 : acc_len;
  localparam int CW = $clog2(M2 + 1);
  localparam int KW = $clog2(kij_len + 1);
  localparam int OW = $clog2(nij_len + 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [KW-1:0] r_kij;
  logic [OW-1:0] r_ofcnt;
  logic [1:0]    r_inst_w;
  logic          r_mode;
  logic          r_err;

  logic [2:0] w_nxt;
  logic       w_last;
  logic       w_wr;
  logic       w_kij_last;
  logic       w_drain_done;

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_WLOAD:   w_last = (r_cnt == CW'(row - 1));
      S_WSETTLE: w_last = (r_cnt == CW'(row + col - 1));
      S_EXEC:    w_last = (r_cnt == CW'(nij_len - 1));
      S_ACC:     w_last = (r_cnt == CW'(acc_len - 1));
      default:   w_last = 1'b0;
    endcase
  end

  // Lines are only accepted while a kij is in flight and not yet full.
  assign w_wr = ofifo_vld
              && (r_state == S_EXEC || r_state == S_DRAIN)
              && (r_ofcnt != OW'(nij_len));
  assign w_kij_last   = (r_kij == KW'(kij_len - 1));
  assign w_drain_done = (r_state == S_DRAIN)
                      && (r_ofcnt == OW'(nij_len));

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_nxt = S_CLR;
      S_CLR:     w_nxt = S_WLOAD;
      S_WLOAD:   if (w_last) w_nxt = S_WSETTLE;
      S_WSETTLE: if (w_last) w_nxt = S_EXEC;
      S_EXEC:    if (w_last) w_nxt = S_DRAIN;
      S_DRAIN:
        if (w_drain_done)
          w_nxt = w_kij_last ? S_ACC : S_CLR;
      S_ACC:     if (w_last) w_nxt = S_FIN;
      S_FIN:     w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_kij    <= '0;
      r_ofcnt  <= '0;
      r_inst_w <= 2'b00;
      r_mode   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? '0 : r_cnt + 1'b1;
      if (r_state == S_IDLE && start) begin
        r_mode <= cfg_2bit;
        r_kij  <= '0;
      end
      if (w_nxt == S_CLR && r_state != S_CLR)
        r_ofcnt <= '0;
      else if (w_wr)
        r_ofcnt <= r_ofcnt + 1'b1;
      if (w_drain_done && !w_kij_last)
        r_kij <= r_kij + 1'b1;
      // SRAM data arrives a cycle after the read, so the strobe trails it.
      r_inst_w <= {r_state == S_EXEC, r_state == S_WLOAD};
      if (ofifo_vld && !w_wr)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    x_addr = '0;
    case (r_state)
      S_WLOAD: x_addr = aw'(int'(r_kij) * row + int'(r_cnt));
      S_EXEC:  x_addr = aw'(kij_len * row + int'(r_cnt));
      default: x_addr = '0;
    endcase
  end

  assign p_addr = w_wr
                ? aw'(int'(r_kij) * nij_len + int'(r_ofcnt))
                : '0;
  assign p_wen     = !w_wr;
  assign inst_w    = r_inst_w;
  assign load      = (r_state == S_CLR);
  assign acc       = (r_state == S_ACC);
  assign mode_2bit = r_mode;
  assign x_cen     = !(r_state == S_WLOAD || r_state == S_EXEC);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign err       = r_err;

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: directed bench for the corelet layer sequencer.
// Reactive ofifo model returns one line per execute strobe.
module tb_corelet_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, cfg_2bit, ofifo_vld;
  logic [1:0]  inst_w;
  logic        load, acc, mode_2bit, x_cen;
  logic [10:0] x_addr;
  logic        p_wen;
  logic [10:0] p_addr;
  logic        busy, done, err;

  corelet_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_2bit(cfg_2bit), .ofifo_vld(ofifo_vld),
    .inst_w(inst_w), .load(load), .acc(acc),
    .mode_2bit(mode_2bit), .x_cen(x_cen), .x_addr(x_addr),
    .p_wen(p_wen), .p_addr(p_addr), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit       load;
    bit [1:0] iw;
    bit       xcen;
    int       xaddr;
  } vec_t;

  vec_t vt[11];

  int checks = 0, failures = 0;
  int ncyc, exp_p, nwr, ndone, nacc, sent;
  bit inj_en, inj_done;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    bit vld, inj_now;
    @(posedge clk);
    #1;
    ncyc++;
    inj_now = 1'b0;
    vld = (inst_w == 2'b10);
    if (vld) sent++;
    else if (inj_en && !inj_done && sent == 16) begin
      vld = 1'b1;
      inj_done = 1'b1;
      inj_now = 1'b1;
    end
    ofifo_vld = vld;
    #1;
    if (inj_now) chk("extra_no_write", p_wen, 1);
    if (!p_wen) begin
      chk("p_addr", p_addr, exp_p);
      exp_p++;
      nwr++;
    end
    if (done) ndone++;
    if (acc) nacc++;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_inst_w"}, inst_w, 0);
    chk({pfx, "_load"}, load, 0);
    chk({pfx, "_acc"}, acc, 0);
    chk({pfx, "_mode"}, mode_2bit, 0);
    chk({pfx, "_x_cen"}, x_cen, 1);
    chk({pfx, "_x_addr"}, x_addr, 0);
    chk({pfx, "_p_wen"}, p_wen, 1);
    chk({pfx, "_p_addr"}, p_addr, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_err"}, err, 0);
  endtask

  task automatic clear_counts();
    ncyc = 0; exp_p = 0; nwr = 0; ndone = 0;
    nacc = 0; sent = 0; inj_done = 1'b0;
  endtask

  task automatic run_layer(input bit cfg, input bit inj,
                           input bit poke);
    clear_counts();
    inj_en = inj;
    cfg_2bit = cfg;
    start = 1'b1;
    for (int n = 0; n < 1000 && ndone == 0; n++) begin
      cyc();
      start = poke && (ncyc == 30);
      if (ncyc == 50) cfg_2bit = !cfg;
      if (ncyc == 1) chk("mode_latch", mode_2bit, cfg);
      if (ncyc == 60) chk("mode_hold", mode_2bit, cfg);
      if (ncyc == 31) chk("busy_exec", busy, 1);
      for (int i = 0; i < 11; i++)
        if (vt[i].cyc == ncyc) begin
          chk("tbl_load", load, vt[i].load);
          chk("tbl_inst_w", inst_w, vt[i].iw);
          chk("tbl_x_cen", x_cen, vt[i].xcen);
          chk("tbl_x_addr", x_addr, vt[i].xaddr);
          chk("tbl_busy", busy, 1);
        end
    end
    chk("done_seen", ndone, 1);
    chk("done_cycle", ncyc, 424);
    start = poke;
    cyc();
    start = 1'b0;
    chk("idle_busy", busy, 0);
    cyc();
    chk("no_restart_busy", busy, 0);
    chk("no_restart_load", load, 0);
    chk("done_once", ndone, 1);
    chk("psum_writes", nwr, 144);
    chk("acc_cycles", nacc, 36);
    chk("mode_end", mode_2bit, cfg);
  endtask

  initial begin
    vt[0]  = '{1,  1'b1, 2'b00, 1'b1, 0};
    vt[1]  = '{2,  1'b0, 2'b00, 1'b0, 0};
    vt[2]  = '{3,  1'b0, 2'b01, 1'b0, 1};
    vt[3]  = '{9,  1'b0, 2'b01, 1'b0, 7};
    vt[4]  = '{10, 1'b0, 2'b01, 1'b1, 0};
    vt[5]  = '{11, 1'b0, 2'b00, 1'b1, 0};
    vt[6]  = '{25, 1'b0, 2'b00, 1'b1, 0};
    vt[7]  = '{26, 1'b0, 2'b00, 1'b0, 72};
    vt[8]  = '{27, 1'b0, 2'b10, 1'b0, 73};
    vt[9]  = '{41, 1'b0, 2'b10, 1'b0, 87};
    vt[10] = '{42, 1'b0, 2'b10, 1'b1, 0};

    reset = 1'b1; start = 1'b0;
    cfg_2bit = 1'b0; ofifo_vld = 1'b0;
    inj_en = 1'b0;
    clear_counts();
    repeat (2) cyc();
    chk_reset("rst");
    reset = 1'b0;
    cyc();
    chk("idle_busy0", busy, 0);

    run_layer(1'b0, 1'b0, 1'b1);
    chk("err_clean", err, 0);

    run_layer(1'b1, 1'b1, 1'b0);
    chk("err_sticky", err, 1);

    clear_counts();
    inj_en = 1'b0;
    cfg_2bit = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("mode_relatch", mode_2bit, 0);
    for (int n = 0; n < 1000 && nwr < 52; n++) cyc();
    chk("mid_exec_busy", busy, 1);
    chk("mid_exec_x_cen", x_cen, 0);
    reset = 1'b1;
    cyc();
    chk_reset("abort");
    reset = 1'b0;
    repeat (5) cyc();
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
